// File: rtl/multi_4_row_bypass.sv
// Unsigned 4x4 row-bypassing array multiplier with a registered 8-bit product.
// Each adder row whose multiplier bit is 0 has its operands forced to zero,
// so it does not toggle, and a mux passes the previous running sum straight through.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  qualifies a and b this cycle
//   a         multiplicand (4 bits, unsigned)
//   b         multiplier (4 bits, unsigned); b[i] enables row i
//   pro       registered product (8 bits)
//   out_valid pro holds a new product

// One-bit full adder.
module multi_4_row_bypass_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// One ripple row of four full adders plus its bypass mux.
// Adds a to the running sum when en is set; otherwise it forwards the running
// sum shifted down by one (the same result as adding zero).
module multi_4_row_bypass_row (
    input  logic [3:0] a,
    input  logic [3:0] sum_in,
    input  logic       en,
    output logic       lsb,
    output logic [3:0] sum_out
);
    logic [3:0] op_a;
    logic [3:0] op_s;
    logic [3:0] fa_sum;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       cout;
    logic [4:0] add_res;
    logic [4:0] row_out;

    // Operand gating keeps a bypassed row quiet.
    assign op_a = en ? a : 4'h0;
    assign op_s = en ? sum_in : 4'h0;

    multi_4_row_bypass_fa u_fa0 (.x(op_a[0]), .y(op_s[0]), .ci(1'b0), .s(fa_sum[0]), .co(c1));
    multi_4_row_bypass_fa u_fa1 (.x(op_a[1]), .y(op_s[1]), .ci(c1),   .s(fa_sum[1]), .co(c2));
    multi_4_row_bypass_fa u_fa2 (.x(op_a[2]), .y(op_s[2]), .ci(c2),   .s(fa_sum[2]), .co(c3));
    multi_4_row_bypass_fa u_fa3 (.x(op_a[3]), .y(op_s[3]), .ci(c3),   .s(fa_sum[3]), .co(cout));

    assign add_res = {cout, fa_sum};

    // Bypass: previous sum bits pass unchanged, carry-in position becomes 0.
    assign row_out = en ? add_res : {1'b0, sum_in};

    assign lsb     = row_out[0];
    assign sum_out = row_out[4:1];
endmodule

// Top: row 0 is a plain AND row, rows 1..3 are bypassable adder rows.
module multi_4_row_bypass (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] pro,
    output logic       out_valid
);
    localparam int unsigned AW = 4;
    localparam int unsigned PW = 2 * AW;

    logic [AW-1:0] pp0;
    logic [AW-1:0] run0;
    logic [AW-1:0] run1;
    logic [AW-1:0] run2;
    logic [AW-1:0] run3;
    logic          lsb1;
    logic          lsb2;
    logic          lsb3;
    logic [PW-1:0] pro_c;

    assign pp0  = a & {AW{b[0]}};
    assign run0 = {1'b0, pp0[AW-1:1]};

    multi_4_row_bypass_row u_row1 (.a(a), .sum_in(run0), .en(b[1]), .lsb(lsb1), .sum_out(run1));
    multi_4_row_bypass_row u_row2 (.a(a), .sum_in(run1), .en(b[2]), .lsb(lsb2), .sum_out(run2));
    multi_4_row_bypass_row u_row3 (.a(a), .sum_in(run2), .en(b[3]), .lsb(lsb3), .sum_out(run3));

    // Final row's running sum forms the top nibble.
    assign pro_c = {run3, lsb3, lsb2, lsb1, pp0[0]};

    // Output register: capture on in_valid, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pro       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                pro <= pro_c;
            end
            out_valid <= in_valid;
        end
    end
endmodule

// File: tb/tb_multi_4_row_bypass.sv
// Self-checking bench for multi_4_row_bypass: a cycle model of the product
// register compared every falling edge, plus directed literal expectations.
module tb_multi_4_row_bypass;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] pro;
    logic       out_valid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] m_pro   = 8'h00;
    logic       m_valid = 1'b0;

    multi_4_row_bypass dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .pro(pro),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: product of the sampled operands, held when idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pro   <= 8'h00;
            m_valid <= 1'b0;
        end else begin
            if (in_valid) m_pro <= 8'(a) * 8'(b);
            m_valid <= in_valid;
        end
    end

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (pro !== m_pro) begin
                errors++;
                $display("FAIL model_pro t=%0t got %0d want %0d", $time, pro, m_pro);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL model_valid t=%0t got %0b want %0b", $time, out_valid, m_valid);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got_p, input logic got_v,
                         input logic [7:0] exp_p, input logic exp_v);
        checks++;
        if (got_p !== exp_p || got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got pro=%0d valid=%0b want pro=%0d valid=%0b",
                     name, got_p, got_v, exp_p, exp_v);
        end
    endtask

    // Issue one product, then check it one cycle later against a literal.
    task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp_p);
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        check($sformatf("dir_%0dx%0d", x, y), pro, out_valid, exp_p, 1'b1);
        in_valid = 1'b0;
    endtask

    typedef struct { logic [3:0] x; logic [3:0] y; logic [7:0] p; } vec_t;
    vec_t vecs [$];

    initial begin
        vecs = '{
            '{4'd0, 4'd0, 8'd0},   '{4'd1, 4'd1, 8'd1},   '{4'd10, 4'd0, 8'd0},
            '{4'd14, 4'd1, 8'd14}, '{4'd12, 4'd5, 8'd60}, '{4'd14, 4'd3, 8'd42},
            '{4'd15, 4'd2, 8'd30}, '{4'd7, 4'd8, 8'd56},  '{4'd15, 4'd8, 8'd120},
            '{4'd2, 4'd14, 8'd28}, '{4'd9, 4'd6, 8'd54},  '{4'd6, 4'd9, 8'd54},
            '{4'd10, 4'd5, 8'd50}, '{4'd5, 4'd10, 8'd50}, '{4'd8, 4'd7, 8'd56},
            '{4'd13, 4'd3, 8'd39}, '{4'd4, 4'd4, 8'd16},  '{4'd11, 4'd6, 8'd66},
            '{4'd3, 4'd3, 8'd9}
        };

        // Reset held with active inputs.
        rst_n = 1'b0; in_valid = 1'b1; a = 4'd15; b = 4'd15;
        #1;
        check("reset_async", pro, out_valid, 8'd0, 1'b0);
        chk_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", pro, out_valid, 8'd0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", pro, out_valid, 8'd225, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_hold", pro, out_valid, 8'd225, 1'b0);

        // Directed vectors.
        foreach (vecs[k]) issue(vecs[k].x, vecs[k].y, vecs[k].p);

        // All 256 pairs back-to-back; model compare covers each cycle.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            a = 4'(i >> 4); b = 4'(i); in_valid = 1'b1;
        end
        @(negedge clk);
        check("stream_last", pro, out_valid, 8'd225, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_drop", pro, out_valid, 8'd225, 1'b0);
        @(negedge clk);
        check("stream_hold", pro, out_valid, 8'd225, 1'b0);

        // Async reset between edges during a stream.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 4'(i + 11); b = 4'(12 - i); in_valid = 1'b1;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_reset", pro, out_valid, 8'd0, 1'b0);
        @(negedge clk);
        check("midstream_reset_neg", pro, out_valid, 8'd0, 1'b0);
        a = 4'd9; b = 4'd6; in_valid = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_first", pro, out_valid, 8'd54, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_idle", pro, out_valid, 8'd54, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
